dcache_mem_ctrl: RTL and testbench
==================================

# dcache_mem_ctrl

Direct-mapped, write-through, no-write-allocate data cache sitting between the MEM stage and main memory. It serves MEM-stage loads and stores, and it produces the `ReadDataM` and `Cache_Stall` signals. The MEM/WB stage register consumes both: it holds while `Cache_Stall` is high and captures `ReadDataM` when it is low. Misses and all stores are forwarded to a slow main-memory port over a req/ready handshake.

## Interface
- `INDEX_BITS`, default 4: number of line-index bits; the cache has 2^INDEX_BITS lines of 4 words.
- `CLK`  in  1  clock, rising edge.
- `RESETn`  in  1  synchronous, active-low reset.
- `MemtoRegM`  in  1  load request in MEM stage.
- `MemWriteM`  in  1  store request in MEM stage; takes priority over `MemtoRegM` when both are high.
- `ALUOutM`  in  32  byte address. Bits [1:0] are ignored, [3:2] select the word, [3+INDEX_BITS:4] select the index, and the upper bits are the tag.
- `WriteDataM`  in  32  store data.
- `ReadDataM`  out  32  load data; combinational; 0 unless a read hit.
- `Cache_Stall`  out  1  combinational; freezes the pipeline while high.
- `MEM_Req`  out  1  memory request.
- `MEM_WE`  out  1  1 = write, 0 = read.
- `MEM_Addr`  out  32  word-aligned memory address.
- `MEM_WData`  out  32  memory write data.
- `MEM_RData`  in  32  memory read data; valid when `MEM_Ready` = 1.
- `MEM_Ready`  in  1  memory completes the current request at this rising edge.

## Operation
- FSM states: IDLE, REFILL, WRITE.
- IDLE, load, line valid and tag match (hit): `ReadDataM` = cached word, `Cache_Stall` = 0.
- IDLE, load miss: `Cache_Stall` = 1 in the same cycle.
  - Latch tag/index and clear the word counter.
  - Next state is REFILL.
- REFILL: `MEM_Req` = 1, `MEM_WE` = 0, `MEM_Addr` = {tag, index, cnt, 2'b00}.
  - On each `MEM_Ready`, write `MEM_RData` into word `cnt` and increment `cnt`.
  - On `MEM_Ready` with cnt = 3: set valid, write the tag, go to IDLE.
  - Back in IDLE the stalled load now hits and the stall drops.
- IDLE, store with `done_w` = 0:
  - `Cache_Stall` = 1.
  - Latch address and data.
  - If the store hits, update the cached word at this edge. A store miss leaves the cache untouched.
  - Next state is WRITE.
- WRITE: `MEM_Req` = 1, `MEM_WE` = 1, address and data stable. On `MEM_Ready`, set `done_w` and go to IDLE.
- IDLE, store with `done_w` = 1: `Cache_Stall` = 0 and `done_w` clears at the edge, so the stalled store is not reissued.
- `done_w` also clears on any IDLE cycle with no store.
- `Cache_Stall` = (state ≠ IDLE) OR (IDLE AND (load miss OR (store AND NOT `done_w`))).
- No request in IDLE: `MEM_Req` = 0 and `Cache_Stall` = 0.

## Timing
- Reset values:
  - state = IDLE, all valid bits = 0, `cnt` = 0, `done_w` = 0.
  - `MEM_Req`, `MEM_WE`, `MEM_Addr`, `MEM_WData` = 0.
  - `ReadDataM` = 0, `Cache_Stall` = 0 with no request.
  - Stats counters = 0.
- Reset asserted mid-REFILL or mid-WRITE aborts the transfer:
  - The next cycle is IDLE with `MEM_Req` = 0.
  - The partially filled line stays invalid.
- Read hit: zero-cycle latency, no stall.
- Read miss with `MEM_Ready` tied high: stall lasts 5 cycles (1 IDLE + 4 REFILL); data is valid in cycle 6.
- Each added memory wait cycle adds one stall cycle.
- Store with `MEM_Ready` tied high: stall lasts 2 cycles (IDLE detect + 1 WRITE); the third cycle has stall 0.
- `MEM_Addr`, `MEM_WE` and `MEM_WData` stay stable while `MEM_Req` = 1 and `MEM_Ready` = 0.
- Request inputs are ignored outside IDLE; the pipeline is frozen then.
- A store miss does not evict or allocate.
- A refill overwrites the indexed line regardless of its previous tag.

## Configuration
- `DCACHE_STATS_EN` defined adds two outputs, `HitCount` [31:0] and `MissCount` [31:0], reset to 0. Both wrap at 2^32.
  - `HitCount` increments on each IDLE load hit with `Cache_Stall` = 0, including the post-refill hit.
  - `MissCount` increments once per IDLE→REFILL transition.
  - Stores are not counted.
- `DCACHE_STATS_EN` undefined: these ports and counters do not exist.

## Test plan
- Reset, then load 0x0000_0040 with memory words 0xA0..0xA3 and `MEM_Ready` = 1 → 5 stall cycles, `MEM_Addr` = 0x40, 0x44, 0x48, 0x4C, then `ReadDataM` = 0xA0. A following load of 0x48 hits → 0xA2, no stall.
- Store 0xDEADBEEF to 0x44 after the fill above → 2 stall cycles, `MEM_WE` = 1, `MEM_Addr` = 0x44. A subsequent load of 0x44 → 0xDEADBEEF, no stall, no `MEM_Req`.
- Store to uncached 0x1000 with `MEM_Ready` delayed 3 cycles → stall held 4 cycles, exactly one write transfer, no re-issue, line 0 still invalid.
- Conflict: load 0x40, then load 0x140 (same index, different tag) → second access misses and refills. Reloading 0x40 misses again.
- Assert `RESETn` = 0 during the 2nd REFILL word → next cycle IDLE, `MEM_Req` = 0. Reloading 0x40 performs a full 4-word refill.
- With `DCACHE_STATS_EN`: scenario 1 → `MissCount` = 1, `HitCount` = 2.

Source files
------------

// File: rtl/dcache_mem_ctrl.sv
// Direct-mapped, write-through, no-write-allocate data cache between the
// MEM stage and a slow main-memory port. Loads that miss refill a whole
// 4-word line; every store is written through to memory, and a store that
// hits also updates the cached word. The pipeline is frozen via Cache_Stall
// while a memory transfer is outstanding.
//
// Optional build macro: DCACHE_STATS_EN adds the HitCount / MissCount
// statistics outputs. With the macro undefined those ports do not exist.
module dcache_mem_ctrl #(
  parameter int INDEX_BITS = 4
) (
  input  logic        CLK,
  input  logic        RESETn,
  input  logic        MemtoRegM,
  input  logic        MemWriteM,
  input  logic [31:0] ALUOutM,
  input  logic [31:0] WriteDataM,
  output logic [31:0] ReadDataM,
  output logic        Cache_Stall,
  output logic        MEM_Req,
  output logic        MEM_WE,
  output logic [31:0] MEM_Addr,
  output logic [31:0] MEM_WData,
  input  logic [31:0] MEM_RData,
  input  logic        MEM_Ready
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0] HitCount,
  output logic [31:0] MissCount
`endif
);

  localparam int LINES = 1 << INDEX_BITS;
  localparam int WORDS = LINES * 4;
  localparam int TAG_W = 28 - INDEX_BITS;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REFILL = 2'd1,
    WRITE  = 2'd2
  } state_t;

  state_t state;
  state_t state_next;

  // Address fields of the current MEM-stage request
  logic [TAG_W-1:0]      req_tag;
  logic [INDEX_BITS-1:0] req_index;
  logic [1:0]            req_word;
  logic                  unused_addr_lsbs;

  assign req_tag          = ALUOutM[31:4+INDEX_BITS];
  assign req_index        = ALUOutM[3+INDEX_BITS:4];
  assign req_word         = ALUOutM[3:2];
  assign unused_addr_lsbs = ^ALUOutM[1:0];

  // Cache storage: data and tags carry no reset, only the valid bits do
  logic [31:0]      data_mem [WORDS];
  logic [TAG_W-1:0] tag_mem  [LINES];
  logic [LINES-1:0] valid;

  // Transfer bookkeeping
  logic [1:0]            cnt;
  logic                  done_w;
  logic [TAG_W-1:0]      fill_tag;
  logic [INDEX_BITS-1:0] fill_index;
  logic [31:0]           wr_addr;
  logic [31:0]           wr_data;

  // Lookup for the request presented in IDLE
  logic        line_hit;
  logic [31:0] cached_word;

  assign line_hit    = valid[req_index] && (tag_mem[req_index] == req_tag);
  assign cached_word = data_mem[{req_index, req_word}];

  // Per-cycle strobes decoded by the FSM
  logic start_refill;
  logic start_write;
  logic refill_wr;
  logic refill_last;
  logic write_done;
  logic load_hit;

  assign refill_last = refill_wr && (cnt == 2'd3);

  // State register
  always_ff @(posedge CLK) begin
    if (!RESETn) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state, pipeline handshake and memory-port outputs
  always_comb begin
    state_next   = state;
    ReadDataM    = 32'd0;
    Cache_Stall  = 1'b0;
    MEM_Req      = 1'b0;
    MEM_WE       = 1'b0;
    MEM_Addr     = 32'd0;
    MEM_WData    = 32'd0;
    start_refill = 1'b0;
    start_write  = 1'b0;
    refill_wr    = 1'b0;
    write_done   = 1'b0;
    load_hit     = 1'b0;

    case (state)
      IDLE: begin
        if (MemWriteM) begin
          // A store that has already been written through is let go
          // without a second transfer; done_w remembers that.
          if (!done_w) begin
            Cache_Stall = 1'b1;
            start_write = 1'b1;
            state_next  = WRITE;
          end
        end else if (MemtoRegM) begin
          if (line_hit) begin
            ReadDataM = cached_word;
            load_hit  = 1'b1;
          end else begin
            Cache_Stall  = 1'b1;
            start_refill = 1'b1;
            state_next   = REFILL;
          end
        end
      end

      REFILL: begin
        Cache_Stall = 1'b1;
        MEM_Req     = 1'b1;
        MEM_Addr    = {fill_tag, fill_index, cnt, 2'b00};
        if (MEM_Ready) begin
          refill_wr = 1'b1;
          if (cnt == 2'd3) begin
            state_next = IDLE;
          end
        end
      end

      WRITE: begin
        Cache_Stall = 1'b1;
        MEM_Req     = 1'b1;
        MEM_WE      = 1'b1;
        MEM_Addr    = wr_addr;
        MEM_WData   = wr_data;
        if (MEM_Ready) begin
          write_done = 1'b1;
          state_next = IDLE;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Control state: refill word counter, store-done flag and valid bits
  always_ff @(posedge CLK) begin
    if (!RESETn) begin
      cnt    <= 2'd0;
      done_w <= 1'b0;
      valid  <= '0;
    end else begin
      if (start_refill) begin
        cnt <= 2'd0;
      end else if (refill_wr) begin
        cnt <= cnt + 2'd1;
      end

      if (write_done) begin
        done_w <= 1'b1;
      end else if (state == IDLE) begin
        done_w <= 1'b0;
      end

      if (refill_last) begin
        valid[fill_index] <= 1'b1;
      end
    end
  end

  // Datapath: request latches, line data and tag writes
  always_ff @(posedge CLK) begin
    if (start_refill) begin
      fill_tag   <= req_tag;
      fill_index <= req_index;
    end

    if (start_write) begin
      wr_addr <= {ALUOutM[31:2], 2'b00};
      wr_data <= WriteDataM;
      if (line_hit) begin
        data_mem[{req_index, req_word}] <= WriteDataM;
      end
    end

    if (refill_wr) begin
      data_mem[{fill_index, cnt}] <= MEM_RData;
    end

    if (refill_last) begin
      tag_mem[fill_index] <= fill_tag;
    end
  end

`ifdef DCACHE_STATS_EN
  // Hit/miss statistics; stores are not counted, both counters wrap
  always_ff @(posedge CLK) begin
    if (!RESETn) begin
      HitCount  <= 32'd0;
      MissCount <= 32'd0;
    end else begin
      if (load_hit) begin
        HitCount <= HitCount + 32'd1;
      end
      if (start_refill) begin
        MissCount <= MissCount + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_dcache_mem_ctrl.sv
// Testbench for dcache_mem_ctrl: directed scenarios followed by random
// loads/stores against a line-level reference model. The model only tracks
// which tag each line holds; since the cache is write-through, a hit must
// return whatever the memory model currently holds at that address.
module tb_dcache_mem_ctrl;

  logic        CLK = 1'b0;
  logic        RESETn = 1'b0;
  logic        MemtoRegM = 1'b0;
  logic        MemWriteM = 1'b0;
  logic [31:0] ALUOutM = 32'd0;
  logic [31:0] WriteDataM = 32'd0;
  logic [31:0] ReadDataM;
  logic        Cache_Stall;
  logic        MEM_Req;
  logic        MEM_WE;
  logic [31:0] MEM_Addr;
  logic [31:0] MEM_WData;
  logic [31:0] MEM_RData = 32'd0;
  logic        MEM_Ready = 1'b0;
`ifdef DCACHE_STATS_EN
  logic [31:0] HitCount;
  logic [31:0] MissCount;
  int          m_hits = 0;
  int          m_misses = 0;
`endif

  always #5 CLK = ~CLK;

  dcache_mem_ctrl #(.INDEX_BITS(4)) dut (
    .CLK        (CLK),
    .RESETn     (RESETn),
    .MemtoRegM  (MemtoRegM),
    .MemWriteM  (MemWriteM),
    .ALUOutM    (ALUOutM),
    .WriteDataM (WriteDataM),
    .ReadDataM  (ReadDataM),
    .Cache_Stall(Cache_Stall),
    .MEM_Req    (MEM_Req),
    .MEM_WE     (MEM_WE),
    .MEM_Addr   (MEM_Addr),
    .MEM_WData  (MEM_WData),
    .MEM_RData  (MEM_RData),
    .MEM_Ready  (MEM_Ready)
`ifdef DCACHE_STATS_EN
    ,
    .HitCount   (HitCount),
    .MissCount  (MissCount)
`endif
  );

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Main-memory model: written words live in the associative array,
  // untouched words come from a fixed pattern (0x40..0x4C hold 0xA0..0xA3)
  logic [31:0] mem_model [logic [31:0]];

  function automatic logic [31:0] mem_value(input logic [31:0] a);
    if (mem_model.exists(a)) return mem_model[a];
    if (a >= 32'h40 && a <= 32'h4C) return 32'hA0 + ((a - 32'h40) >> 2);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  // Memory responder: waits mem_wait extra cycles per word, then raises
  // MEM_Ready for one cycle and logs the transfer
  int          mem_wait = 0;
  int          wait_cnt = 0;
  logic [31:0] xa_q[$];
  logic        xw_q[$];
  logic [31:0] xd_q[$];

  always @(negedge CLK) begin
    if (MEM_Ready) wait_cnt = 0;
    MEM_Ready = 1'b0;
    if (RESETn && MEM_Req) begin
      if (wait_cnt >= mem_wait) begin
        MEM_Ready = 1'b1;
        MEM_RData = mem_value(MEM_Addr);
        if (MEM_WE) mem_model[MEM_Addr] = MEM_WData;
        xa_q.push_back(MEM_Addr);
        xw_q.push_back(MEM_WE);
        xd_q.push_back(MEM_WData);
      end else begin
        wait_cnt++;
      end
    end else begin
      wait_cnt = 0;
    end
  end

  // Line-level cache model
  bit          m_valid [16];
  logic [23:0] m_tag   [16];

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
`ifdef DCACHE_STATS_EN
    m_hits = 0;
    m_misses = 0;
`endif
  endtask

  task automatic clear_log();
    xa_q.delete();
    xw_q.delete();
    xd_q.delete();
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RESETn = 1'b0;
    MemtoRegM = 1'b0;
    MemWriteM = 1'b0;
    repeat (2) @(negedge CLK);
    RESETn = 1'b1;
    model_reset();
    clear_log();
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge CLK);
      MemtoRegM = 1'b0;
      MemWriteM = 1'b0;
      ALUOutM = $urandom;
      WriteDataM = $urandom;
      #1;
      check_eq("idle_stall", 32'(Cache_Stall), 32'd0);
      check_eq("idle_req", 32'(MEM_Req), 32'd0);
    end
  endtask

  // One pipeline access; returns in the cycle where the stall has dropped
  task automatic access(input bit st, input bit also_load, input logic [31:0] addr,
                        input logic [31:0] wd);
    logic [3:0]  idx;
    logic [23:0] tg;
    bit          hit;
    int          exp_stall;
    int          stall;
    logic [31:0] exp_a;

    idx = addr[7:4];
    tg  = addr[31:8];
    hit = !st && m_valid[idx] && (m_tag[idx] == tg);
    if (st) exp_stall = 2 + mem_wait;
    else if (hit) exp_stall = 0;
    else exp_stall = 5 + 4 * mem_wait;

    clear_log();
    @(negedge CLK);
    MemWriteM  = st;
    MemtoRegM  = !st || also_load;
    ALUOutM    = addr | 32'($urandom_range(0, 3));
    WriteDataM = wd;
    stall = 0;
    #1;
    if (hit) check_eq("hit_req", 32'(MEM_Req), 32'd0);
    while (Cache_Stall && stall < 200) begin
      stall++;
      @(negedge CLK);
      #1;
    end
    check_eq(st ? "st_stall" : (hit ? "hit_stall" : "miss_stall"), stall, exp_stall);

    if (!st) check_eq("rdata", ReadDataM, mem_value(addr));

    if (st) begin
      check_eq("st_nxfer", xa_q.size(), 1);
      if (xa_q.size() >= 1) begin
        check_eq("st_addr", xa_q[0], addr);
        check_eq("st_we", 32'(xw_q[0]), 32'd1);
        check_eq("st_data", xd_q[0], wd);
      end
    end else if (!hit) begin
      check_eq("fill_nxfer", xa_q.size(), 4);
      for (int i = 0; i < 4 && i < xa_q.size(); i++) begin
        exp_a = {addr[31:4], 4'(i * 4)};
        check_eq("fill_addr", xa_q[i], exp_a);
        check_eq("fill_we", 32'(xw_q[i]), 32'd0);
      end
    end else begin
      check_eq("hit_nxfer", xa_q.size(), 0);
    end

    if (!st) begin
      m_valid[idx] = 1'b1;
      m_tag[idx]   = tg;
`ifdef DCACHE_STATS_EN
      m_hits++;
      if (!hit) m_misses++;
`endif
    end
  endtask

  initial begin
    logic [31:0] a;
    logic [31:0] tags [4];
    bit          st;

    tags[0] = 32'h0;
    tags[1] = 32'h1;
    tags[2] = 32'h10;
    tags[3] = 32'hABCDE;

    // Reset state with no request
    do_reset();
    #1;
    check_eq("rst_stall", 32'(Cache_Stall), 32'd0);
    check_eq("rst_req", 32'(MEM_Req), 32'd0);
    check_eq("rst_we", 32'(MEM_WE), 32'd0);
    check_eq("rst_addr", MEM_Addr, 32'd0);
    check_eq("rst_wdata", MEM_WData, 32'd0);
    check_eq("rst_rdata", ReadDataM, 32'd0);

    // Scenario 1: cold miss then hit in the same line
    mem_wait = 0;
    access(1'b0, 1'b0, 32'h40, 32'd0);
    check_eq("s1_first", ReadDataM, 32'hA0);
    access(1'b0, 1'b0, 32'h48, 32'd0);
    check_eq("s1_hit", ReadDataM, 32'hA2);
    idle(1);
`ifdef DCACHE_STATS_EN
    check_eq("s1_misscnt", MissCount, 32'd1);
    check_eq("s1_hitcnt", HitCount, 32'd2);
`endif

    // Scenario 2: store hit is written through and updates the line
    access(1'b1, 1'b0, 32'h44, 32'hDEADBEEF);
    access(1'b0, 1'b0, 32'h44, 32'd0);
    check_eq("s2_load", ReadDataM, 32'hDEADBEEF);
    idle(1);

    // Scenario 3: store miss with a slow memory (Ready on 3rd request cycle)
    do_reset();
    mem_wait = 2;
    access(1'b1, 1'b0, 32'h1000, 32'h1234_5678);
    clear_log();
    idle(3);
    check_eq("s3_no_reissue", xa_q.size(), 0);
    mem_wait = 0;
    access(1'b0, 1'b0, 32'h1000, 32'd0);
    check_eq("s3_load", ReadDataM, 32'h1234_5678);

    // Scenario 4: conflicting tags on the same index
    access(1'b0, 1'b0, 32'h40, 32'd0);
    access(1'b0, 1'b0, 32'h140, 32'd0);
    access(1'b0, 1'b0, 32'h40, 32'd0);
    idle(1);

    // Scenario 5: reset during the second refill word
    do_reset();
    @(negedge CLK);
    MemtoRegM = 1'b1;
    ALUOutM = 32'h40;
    @(negedge CLK);
    @(negedge CLK);
    #1;
    check_eq("abort_addr", MEM_Addr, 32'h44);
    RESETn = 1'b0;
    MemtoRegM = 1'b0;
    @(negedge CLK);
    #1;
    check_eq("abort_req", 32'(MEM_Req), 32'd0);
    check_eq("abort_stall", 32'(Cache_Stall), 32'd0);
    RESETn = 1'b1;
    model_reset();
    access(1'b0, 1'b0, 32'h40, 32'd0);
    idle(1);

    // Random traffic over a few indices and conflicting tags
    for (int n = 0; n < 300; n++) begin
      mem_wait = $urandom_range(0, 2);
      a = {tags[$urandom_range(0, 3)][23:0], 4'($urandom_range(0, 3)),
           2'($urandom_range(0, 3)), 2'b00};
      st = ($urandom_range(0, 2) == 0);
      access(st, st && ($urandom_range(0, 3) == 0), a, $urandom);
      if ($urandom_range(0, 4) == 0) idle(1);
    end
    idle(1);
`ifdef DCACHE_STATS_EN
    check_eq("rnd_hitcnt", HitCount, 32'(m_hits));
    check_eq("rnd_misscnt", MissCount, 32'(m_misses));
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
